multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle RV32I core; parametrised successor to the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Adds a memory req/ready handshake with timeout, an illegal-opcode trap with optional halt, and optional AUIPC support.
- Sits between the instruction register (op field) and the multicycle datapath; feeds aludec via alu_op.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus_err; 0 = no timeout
ILLEGAL_HALT, 0, 1 = illegal opcode enters HALT until reset; 0 = pulse illegal_instr then refetch

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  7  opcode from instruction register
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_write  out  1  store request (only with mem_req)
adr_src  out  1  0 = PC, 1 = ALUOut as memory address
ir_write  out  1  load IR and OldPC
pc_update  out  1  unconditional PC write
branch  out  1  PC write if Zero
reg_write  out  1  register-file write
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 ImmExt, 10 const 4
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op, any state
illegal_instr  out  1  one-cycle pulse; level in HALT
bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- State register updates on posedge clk. reset=1 forces next state FETCH and clears the wait counter. While reset=1, all outputs except imm_src are 0.
- Outputs not listed for a state are 0. alu_src_a, alu_src_b and alu_op are 00 unless listed.
- FETCH: mem_req, adr_src=0, alu_src_b=10, result_src=10. On mem_ready: ir_write and pc_update, go to DECODE. Otherwise hold.
- DECODE: alu_src_a=01, alu_src_b=01 (branch/jump target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write -> FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. On mem_ready go to FETCH.
- EXECR: alu_src_a=10, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write -> FETCH.
- BEQ: alu_src_a=10, alu_op=01, result_src=00, branch -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update -> ALUWB.
- JALR: alu_src_a=10, alu_src_b=01, result_src=10, pc_update -> JALRWB.
- JALRWB: alu_src_a=01, alu_src_b=10, result_src=10, reg_write -> FETCH.
- LUI: result_src=11, reg_write -> FETCH.
- ILLEGAL: illegal_instr=1.
  - ILLEGAL_HALT=0: go to FETCH.
  - ILLEGAL_HALT=1: go to HALT.
- HALT: illegal_instr=1, all other outputs 0, remain until reset.
- Wait counter:
  - Counts cycles spent in FETCH/MEMREAD/MEMWRITE with mem_ready=0; clears on any state change.
  - If it reaches MEM_TIMEOUT-1 with mem_ready still 0: bus_err=1 that cycle, next state FETCH, no ir_write/reg_write/pc_update.
  - mem_ready and timeout in the same cycle: mem_ready wins, no bus_err.
- mem_ready outside a request state is ignored.
- Latencies with mem_ready immediate:
  - R/I/LUI/BEQ: 3–4 cycles
  - LW: 5
  - SW: 4
  - JAL: 4
  - JALR: 4
- Reset mid-access: request is abandoned; FETCH on the next cycle, no write strobes.

Optional Feature:
MULTICYCLE_CTRL_AUIPC_EN
- Defined: op 0010111 decodes in DECODE to state AUIPC, then ALUWB.
  - AUIPC state: alu_src_a=01, alu_src_b=01, alu_op=00.
  - imm_src=100 for this opcode.
- Undefined: 0010111 is illegal and imm_src is 000.

Test Plan:
- Reset, then op=0110011 with mem_ready held 1 -> states FETCH, DECODE, EXECR, ALUWB; reg_write high exactly in cycle 4, alu_op=10 in EXECR.
- op=0000011, mem_ready low 3 cycles in MEMREAD -> mem_req held 4 cycles, adr_src=1; MEMWB asserts result_src=01 and reg_write once.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err pulses in the 4th wait cycle, then FETCH restarts, ir_write never asserted.
- op=1111111, both ILLEGAL_HALT values:
  - 0 -> single illegal_instr pulse, then mem_req in the next cycle.
  - 1 -> illegal_instr stays high until reset=1; FETCH follows reset.
- op=1100111 -> JALR: pc_update with alu_src_a=10/alu_src_b=01; JALRWB: reg_write with alu_src_a=01/alu_src_b=10, result_src=10.
- op=0010111 -> macro defined: AUIPC state then ALUWB, imm_src=100; undefined: illegal_instr pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback over one memory port.
// Optional macro MULTICYCLE_CTRL_AUIPC_EN adds AUIPC (op 0010111); without it that opcode traps as illegal.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic       bus_err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALRWB, S_LUI, S_AUIPC, S_ILLEGAL, S_HALT
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.result_src = 2'b00; c.reg_write = 1'b1; end
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_update = 1'b1; end
      S_JALRWB:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.reg_write = 1'b1; end
      S_LUI:      begin c.result_src = 2'b11; c.reg_write = 1'b1; end
      S_AUIPC:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_ILLEGAL:  begin c.illegal_instr = 1'b1; end
      S_HALT:     begin c.illegal_instr = 1'b1; end
      default:    begin c = '0; end
    endcase
    return c;
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  ctrl_t           ctrl_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            req_state_s;
  logic            timeout_s;
  logic            fetch_done_s;

  assign req_state_s  = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
  assign timeout_s    = (MEM_TIMEOUT != 0) && req_state_s && !mem_ready && (wait_cnt_r == WAIT_MAX);
  assign fetch_done_s = (state_r == S_FETCH) && mem_ready;

  // Next-state selection; a timed-out access abandons the instruction and refetches
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:    if (mem_ready) next_state_s = S_DECODE; else next_state_s = S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_BRNCH:          next_state_s = S_BEQ;
          OP_JAL:            next_state_s = S_JAL;
          OP_JALR:           next_state_s = S_JALR;
          OP_LUI:            next_state_s = S_LUI;
`ifdef MULTICYCLE_CTRL_AUIPC_EN
          OP_AUIPC:          next_state_s = S_AUIPC;
`endif
          default:           next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   if (op == OP_LOAD) next_state_s = S_MEMREAD; else next_state_s = S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)      next_state_s = S_MEMWB;
        else if (timeout_s) next_state_s = S_FETCH;
        else                next_state_s = S_MEMREAD;
      end
      S_MEMWRITE: if (mem_ready || timeout_s) next_state_s = S_FETCH; else next_state_s = S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: next_state_s = S_ALUWB;
      S_JALR:     next_state_s = S_JALRWB;
      S_ILLEGAL:  if (ILLEGAL_HALT != 0) next_state_s = S_HALT; else next_state_s = S_FETCH;
      S_HALT:     next_state_s = S_HALT;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // State, decoded control word and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      ctrl_r     <= ctrl_of(S_FETCH);
      wait_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_of(next_state_s);
      if (req_state_s && !mem_ready && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // Drive outputs from the registered control word; handshake strobes depend on this cycle's mem_ready
  always_comb begin
    if (reset) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      reg_write     = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      illegal_instr = 1'b0;
      bus_err       = 1'b0;
    end else begin
      mem_req       = ctrl_r.mem_req;
      mem_write     = ctrl_r.mem_write;
      adr_src       = ctrl_r.adr_src;
      ir_write      = fetch_done_s;
      pc_update     = ctrl_r.pc_update | fetch_done_s;
      branch        = ctrl_r.branch;
      reg_write     = ctrl_r.reg_write;
      result_src    = ctrl_r.result_src;
      alu_src_a     = ctrl_r.alu_src_a;
      alu_src_b     = ctrl_r.alu_src_b;
      alu_op        = ctrl_r.alu_op;
      illegal_instr = ctrl_r.illegal_instr;
      bus_err       = timeout_s;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE: imm_src = 3'b001;
      OP_BRNCH: imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
`ifdef MULTICYCLE_CTRL_AUIPC_EN
      OP_AUIPC: imm_src = 3'b100;
`endif
      default:  imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-script reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int TO_A = 4;
  localparam int IH_A = 0;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
                P_ALUWB, P_BEQ, P_JAL, P_JALR, P_JALRWB, P_LUI, P_AUIPC, P_ILLEGAL, P_HALT} ph_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, mr_a, reset_b, mr_b;
  logic [6:0] op_a, op_b, next_op;
  logic       a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_update, a_branch, a_reg_write;
  logic       a_illegal, a_bus_err, b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_update;
  logic       b_branch, b_reg_write, b_illegal, b_bus_err;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
  logic [2:0] a_imm_src, b_imm_src;
  logic [16:0] act_a, act_b;

  int  n_chk = 0;
  int  n_fail = 0;
  logic load_ir = 1'b0;

  multicycle_ctrl #(.MEM_TIMEOUT(TO_A), .ILLEGAL_HALT(IH_A)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .mem_ready(mr_a),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src), .ir_write(a_ir_write),
    .pc_update(a_pc_update), .branch(a_branch), .reg_write(a_reg_write), .result_src(a_result_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .imm_src(a_imm_src),
    .illegal_instr(a_illegal), .bus_err(a_bus_err));

  multicycle_ctrl #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .mem_ready(mr_b),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src), .ir_write(b_ir_write),
    .pc_update(b_pc_update), .branch(b_branch), .reg_write(b_reg_write), .result_src(b_result_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .imm_src(b_imm_src),
    .illegal_instr(b_illegal), .bus_err(b_bus_err));

  // bit order: mem_req mem_write adr_src ir_write pc_update branch reg_write result_src alu_src_a alu_src_b alu_op illegal bus_err
  assign act_a = {a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_update, a_branch, a_reg_write,
                  a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_illegal, a_bus_err};
  assign act_b = {b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_update, b_branch, b_reg_write,
                  b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_illegal, b_bus_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] phase_out(input ph_e p);
    case (p)
      P_FETCH:    return 17'b1_0_0_0_0_0_0_10_00_10_00_0_0;
      P_DECODE:   return 17'b0_0_0_0_0_0_0_00_01_01_00_0_0;
      P_MEMADR:   return 17'b0_0_0_0_0_0_0_00_10_01_00_0_0;
      P_MEMREAD:  return 17'b1_0_1_0_0_0_0_00_00_00_00_0_0;
      P_MEMWB:    return 17'b0_0_0_0_0_0_1_01_00_00_00_0_0;
      P_MEMWRITE: return 17'b1_1_1_0_0_0_0_00_00_00_00_0_0;
      P_EXECR:    return 17'b0_0_0_0_0_0_0_00_10_00_10_0_0;
      P_EXECI:    return 17'b0_0_0_0_0_0_0_00_10_01_10_0_0;
      P_ALUWB:    return 17'b0_0_0_0_0_0_1_00_00_00_00_0_0;
      P_BEQ:      return 17'b0_0_0_0_0_1_0_00_10_00_01_0_0;
      P_JAL:      return 17'b0_0_0_0_1_0_0_00_01_10_00_0_0;
      P_JALR:     return 17'b0_0_0_0_1_0_0_10_10_01_00_0_0;
      P_JALRWB:   return 17'b0_0_0_0_0_0_1_10_01_10_00_0_0;
      P_LUI:      return 17'b0_0_0_0_0_0_1_11_00_00_00_0_0;
      P_AUIPC:    return 17'b0_0_0_0_0_0_0_00_01_01_00_0_0;
      P_ILLEGAL:  return 17'b0_0_0_0_0_0_0_00_00_00_00_1_0;
      P_HALT:     return 17'b0_0_0_0_0_0_0_00_00_00_00_1_0;
      default:    return 17'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
`ifdef MULTICYCLE_CTRL_AUIPC_EN
      7'b0010111: return 3'b100;
`endif
      default:    return 3'b000;
    endcase
  endfunction

  // Reference model: each decoded instruction expands into a script of phases; request phases wait on mem_ready
  initial begin : model
    ph_e  ph;
    ph_e  scr[$];
    int   wcnt;
    bit   synced;
    bit   done;
    logic [16:0] e;
    ph = P_FETCH; wcnt = 0; synced = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_a) synced = 1'b1;
      if (synced) chk("imm_src", 32'(a_imm_src), 32'(imm_of(op_a)));
      if (reset_a) begin
        chk("reset_outputs", 32'(act_a), 32'd0);
        ph = P_FETCH; wcnt = 0; scr.delete();
        load_ir = 1'b0;
      end else if (synced) begin
        e = phase_out(ph);
        done = 1'b1;
        if (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) begin
          if (mr_a) begin
            if (ph == P_FETCH) begin
              e[13] = 1'b1; e[12] = 1'b1;
              scr.push_back(P_DECODE);
            end
          end else if (TO_A != 0 && wcnt == TO_A - 1) begin
            e[0] = 1'b1;
            scr.delete();
          end else begin
            wcnt++;
            done = 1'b0;
          end
        end else if (ph == P_HALT) begin
          done = 1'b0;
        end
        if (act_a !== e) begin
          n_chk++; n_fail++;
          $display("FAIL cycle_outputs ph=%s op=%b mr=%b got %b expected %b", ph.name(), op_a, mr_a, act_a, e);
        end else begin
          n_chk++;
        end
        load_ir = e[13];
        if (done) begin
          wcnt = 0;
          if (ph == P_DECODE) begin
            case (op_a)
              7'b0000011, 7'b0100011: scr.push_back(P_MEMADR);
              7'b0110011: begin scr.push_back(P_EXECR); scr.push_back(P_ALUWB); end
              7'b0010011: begin scr.push_back(P_EXECI); scr.push_back(P_ALUWB); end
              7'b1100011: scr.push_back(P_BEQ);
              7'b1101111: begin scr.push_back(P_JAL); scr.push_back(P_ALUWB); end
              7'b1100111: begin scr.push_back(P_JALR); scr.push_back(P_JALRWB); end
              7'b0110111: scr.push_back(P_LUI);
`ifdef MULTICYCLE_CTRL_AUIPC_EN
              7'b0010111: begin scr.push_back(P_AUIPC); scr.push_back(P_ALUWB); end
`endif
              default:    scr.push_back(P_ILLEGAL);
            endcase
          end else if (ph == P_MEMADR) begin
            if (op_a == 7'b0000011) begin
              scr.push_back(P_MEMREAD); scr.push_back(P_MEMWB);
            end else begin
              scr.push_back(P_MEMWRITE);
            end
          end else if (ph == P_ILLEGAL && IH_A != 0) begin
            scr.push_back(P_HALT);
          end
          ph = (scr.size() > 0) ? scr.pop_front() : P_FETCH;
        end
      end
    end
  end

  task automatic step(input logic ra, input logic mra, input logic rb, input logic mrb);
    @(posedge clk);
    #1;
    if (load_ir) op_a = next_op;
    reset_a = ra; mr_a = mra; reset_b = rb; mr_b = mrb;
    @(negedge clk);
  endtask

  logic [6:0] op_tab [0:9];
  int         stall;
  logic       r, mr;

  initial begin
    op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    reset_a = 1'b1; reset_b = 1'b1; mr_a = 1'b0; mr_b = 1'b0;
    op_a = 7'b0000000; op_b = 7'b1111111; next_op = 7'b0110011;

    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_a_zero", 32'(act_a), 32'd0);

    // R-type: FETCH, DECODE, EXECR, ALUWB
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r_fetch", 32'({a_mem_req, a_ir_write, a_pc_update}), 32'(3'b111));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r_decode", 32'({a_alu_src_a, a_alu_src_b}), 32'(4'b0101));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r_exec", 32'({a_alu_op, a_reg_write}), 32'(3'b100));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("r_aluwb", 32'(a_reg_write), 32'(1'b1));
    next_op = 7'b0000011;

    // Load with three wait cycles in MEMREAD
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("lw_fetch", 32'({a_mem_req, a_ir_write}), 32'(2'b11));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("lw_memadr", 32'({a_alu_src_a, a_alu_src_b}), 32'(4'b1001));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, (k == 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      chk("lw_memread", 32'({a_mem_req, a_adr_src, a_mem_write, a_reg_write}), 32'(4'b1100));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw_memwb", 32'({a_result_src, a_reg_write}), 32'(3'b011));
    next_op = 7'b1111111;

    // Fetch timeout with MEM_TIMEOUT=4
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_bus_err", 32'({a_bus_err, a_ir_write, a_mem_req}), 32'({(k == 4), 1'b0, 1'b1}));
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("to_refetch", 32'({a_mem_req, a_ir_write, a_bus_err}), 32'(3'b110));

    // Illegal opcode without halt
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ill_pulse", 32'({a_illegal, a_mem_req}), 32'(2'b10));
    next_op = 7'b1100111;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ill_refetch", 32'({a_illegal, a_mem_req}), 32'(2'b01));

    // JALR and JALRWB
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("jalr", 32'({a_pc_update, a_alu_src_a, a_alu_src_b}), 32'(5'b1_10_01));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("jalrwb", 32'({a_reg_write, a_alu_src_a, a_alu_src_b, a_result_src}), 32'(7'b1_01_10_10));
    next_op = 7'b0010111;

    // AUIPC, enabled or trapping
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef MULTICYCLE_CTRL_AUIPC_EN
    chk("auipc", 32'({a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src, a_illegal}), 32'(10'b01_01_00_100_0));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("auipc_wb", 32'(a_reg_write), 32'(1'b1));
`else
    chk("auipc_ill", 32'({a_illegal, a_imm_src}), 32'(4'b1_000));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("auipc_refetch", 32'(a_mem_req), 32'(1'b1));
`endif

    // Second instance: ILLEGAL_HALT=1 and default 16-cycle timeout
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("b_reset", 32'(act_b), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b_fetch", 32'({b_mem_req, b_ir_write}), 32'(2'b11));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b_illegal", 32'(act_b), 32'(17'b10));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, k[0]);
      chk("b_halt", 32'(act_b), 32'(17'b10));
    end
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("b_halt_reset", 32'(act_b), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("b_timeout", 32'({b_bus_err, b_mem_req}), 32'({(k == 16), 1'b1}));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b_after_to", 32'({b_mem_req, b_ir_write, b_bus_err}), 32'(3'b110));

    // Randomized run on the first instance
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 10) == 10) next_op = 7'($urandom_range(0, 127));
      else next_op = op_tab[$urandom_range(0, 9)];
      if (stall > 0) begin
        mr = 1'b0; stall--;
      end else if ($urandom_range(0, 29) == 0) begin
        stall = $urandom_range(3, 6); mr = 1'b0;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
      end
      r = ($urandom_range(0, 149) == 0);
      step(r, mr, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
